regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised integer register file for the pipelined core, successor to the fixed 2R1W 32x32 file.
- Configurable width, depth and read-port count.
- Per-register scoreboard of pending writes: issue sets the bit, writeback clears it.
- Sequential clear engine, so the file can be zeroed at run time without asserting reset.
- Sits between decode/issue (reads and pending checks) and writeback.

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of registers; a power of 2, at least 4; register 0 is hardwired to zero
NRP, 2, number of read ports, at least 1
AW, $clog2(NREG), address width (derived, not overridden)

Ports:
clk  input  1  clock; all state updates on its rising edge
rst  input  1  synchronous reset, active-high
rs_addr  input  NRP*AW  read addresses; port p uses bits [p*AW +: AW]
rs_data  output  NRP*XLEN  read data; port p uses bits [p*XLEN +: XLEN]
rs_busy  output  NRP  port p: its register has a pending write outstanding
rd_wren  input  1  writeback enable
rd_addr  input  AW  writeback address
rd_data  input  XLEN  writeback data
iss_en  input  1  issue: mark iss_addr as pending
iss_addr  input  AW  destination register of the issued instruction
clr_req  input  1  single-cycle pulse: start a run-time clear
clr_busy  output  1  high while a clear is in progress

Behaviour:
- Reset (rst=1 at the clock edge):
  - All registers become 0 and all pending bits become 0.
  - FSM goes to IDLE and the clear counter goes to 0.
  - Reset overrides a clear in progress; it is legal mid-clear.
- Reset values of outputs: clr_busy=0, rs_busy=0, rs_data=0.
- Register 0:
  - Reads always return 0 and rs_busy for it is always 0.
  - Writes and issues to address 0 are ignored.
- Reads are combinational, zero latency, and every port is independent. Any number of ports may read the same address.
- Write: with rd_wren=1 and rd_addr!=0, the register takes rd_data at the edge and its pending bit clears at the same edge.
- Issue: with iss_en=1 and iss_addr!=0, the pending bit is set at the edge.
- Issue and write to the same address in the same cycle: the data is written and the pending bit ends up SET, because the new producer wins.
- rs_busy[p] is the pending bit of rs_addr[p], after the bypass adjustment described under Optional Feature.
- FSM states:
  - IDLE: writes and issues act normally.
  - IDLE to CLEAR: on clr_req=1. The counter loads 1 and clr_busy goes 1 from the next cycle.
  - CLEAR, each cycle: the register at the counter is written 0, its pending bit is cleared, and the counter increments.
  - CLEAR to IDLE: after the counter reaches NREG-1 and that register is cleared. The clear therefore takes exactly NREG-1 cycles with clr_busy=1.
  - During CLEAR: rd_wren, iss_en and clr_req are ignored, and reads return the current stored contents.
- Counter width: AW bits; it never wraps past NREG-1.

Optional Feature:
Macro: REGFILE_BYPASS_EN
- Defined: write-to-read forwarding is enabled.
  - Condition: rd_wren=1, rd_addr!=0, rd_addr==rs_addr[p], FSM in IDLE.
  - When the condition holds, rs_data[p]=rd_data in the same cycle and rs_busy[p]=0, even if iss_en targets the same address that cycle.
- Not defined: no forwarding.
  - rs_data shows the stored value, so a write becomes visible the cycle after the edge.
  - rs_busy is the raw pending bit.

Test Plan:
1. Reset, then drive rs_addr to 0, 5 and 31 -> rs_data=0 and rs_busy=0 on all ports; clr_busy=0.
2. Write 0xDEADBEEF to r0, then read r0 -> 0. Write 0x12345678 to r7, then read r7 the next cycle on both ports -> 0x12345678.
3. Issue r9, then read r9 -> rs_busy=1. Write r9=0xA5A5A5A5 -> rs_busy=0 the next cycle and data=0xA5A5A5A5. Issue and write r9 in the same cycle -> data updated, rs_busy=1 afterwards.
4. Same-cycle write and read of r3=0xCAFEF00D:
   - With REGFILE_BYPASS_EN -> rs_data=0xCAFEF00D and rs_busy=0 in that cycle.
   - Without it -> old value in that cycle, new value the next cycle.
5. Fill r1..r31 with nonzero values and set some pending bits, then pulse clr_req:
   - clr_busy=1 for exactly 31 cycles.
   - Writes and issues during the clear are ignored.
   - Afterwards all reads return 0 and every rs_busy=0.
6. Assert rst 10 cycles into a clear -> clr_busy=0 the next cycle, all registers 0, FSM in IDLE; a following write to r4=0x1 behaves normally.

Source files
------------

// File: rtl/regfile_sb_if.sv
// Bundle of read, writeback, issue and clear signals for the scoreboarded register file.
// No latency of its own; it carries the wires only.
// No backpressure: every request is taken in the cycle it is presented.
interface regfile_sb_if #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int NRP  = 2
);
   localparam int AW = $clog2(NREG);

   logic [NRP*AW-1:0]   rs_addr;
   logic [NRP*XLEN-1:0] rs_data;
   logic [NRP-1:0]      rs_busy;
   logic                rd_wren;
   logic [AW-1:0]       rd_addr;
   logic [XLEN-1:0]     rd_data;
   logic                iss_en;
   logic [AW-1:0]       iss_addr;
   logic                clr_req;
   logic                clr_busy;

   // Decode/issue/writeback side
   modport master (
      output rs_addr, rd_wren, rd_addr, rd_data, iss_en, iss_addr, clr_req,
      input  rs_data, rs_busy, clr_busy
   );

   // Register file side
   modport slave (
      input  rs_addr, rd_wren, rd_addr, rd_data, iss_en, iss_addr, clr_req,
      output rs_data, rs_busy, clr_busy
   );
endinterface

// File: rtl/regfile_sb.sv
// Parametrised integer register file with a per-register pending-write scoreboard and a run-time clear engine.
// Reads are combinational (zero latency); writes, issues and clear steps land at the rising clock edge.
// No backpressure: while clr_busy=1, writes, issues and further clear requests are silently dropped.
// Optional build macro REGFILE_BYPASS_EN forwards same-cycle writeback data and busy to matching read ports.
module regfile_sb #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int NRP  = 2
) (
   input  logic         clk,
   input  logic         rst,
   regfile_sb_if.slave  bus
);
   localparam int AW = $clog2(NREG);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [AW-1:0]       cnt_q, cnt_d;
   logic [XLEN-1:0]     regs_q [NREG];
   logic [NREG-1:0]     pend_q, pend_d;

   logic                wr_en;
   logic [AW-1:0]       wr_addr;
   logic [XLEN-1:0]     wr_dat;
   logic                set_en;

   logic [NRP*XLEN-1:0] rs_data_w;
   logic [NRP-1:0]      rs_busy_w;

   // Clear FSM: picks between the writeback path and the clear engine as the single write source
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_en   = 1'b0;
      wr_addr = bus.rd_addr;
      wr_dat  = bus.rd_data;
      set_en  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            wr_en  = bus.rd_wren && (bus.rd_addr != '0);
            set_en = bus.iss_en && (bus.iss_addr != '0);
            if (bus.clr_req) begin
               state_d = ST_CLEAR;
               cnt_d   = AW'(1);
            end
         end
         ST_CLEAR: begin
            // Register 0 is never stored to, so the sweep starts at 1 and ends at NREG-1
            wr_en   = 1'b1;
            wr_addr = cnt_q;
            wr_dat  = '0;
            if (cnt_q == AW'(NREG - 1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + AW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Scoreboard next state: a write retires the pending bit, a same-cycle issue re-arms it
   always_comb begin
      pend_d = pend_q;
      if (wr_en) begin
         pend_d[wr_addr] = 1'b0;
      end
      if (set_en) begin
         pend_d[bus.iss_addr] = 1'b1;
      end
      pend_d[0] = 1'b0;
   end

   // FSM, clear counter and scoreboard registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
      end
   end

   // Register storage; entry 0 is zeroed by reset and never written afterwards
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en) begin
         regs_q[wr_addr] <= wr_dat;
      end
   end

   // Independent combinational read ports
   for (genvar p = 0; p < NRP; p++) begin : g_rd
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] stored;
      logic            pend;

      assign ra     = bus.rs_addr[p*AW +: AW];
      assign stored = (ra == '0) ? '0 : regs_q[ra];
      assign pend   = (ra == '0) ? 1'b0 : pend_q[ra];
`ifdef REGFILE_BYPASS_EN
      logic byp;
      // Forward the writeback in flight; it also retires any pending producer for this reader
      assign byp = (state_q == ST_IDLE) && bus.rd_wren && (bus.rd_addr != '0) && (bus.rd_addr == ra);
      assign rs_data_w[p*XLEN +: XLEN] = byp ? bus.rd_data : stored;
      assign rs_busy_w[p]              = pend & ~byp;
`else
      assign rs_data_w[p*XLEN +: XLEN] = stored;
      assign rs_busy_w[p]              = pend;
`endif
   end

   assign bus.rs_data  = rs_data_w;
   assign bus.rs_busy  = rs_busy_w;
   assign bus.clr_busy = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic against a behavioural model.
// One task per scenario; outputs are sampled 1-2 time units after the rising edge.
module tb_regfile_sb;
   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int NRP  = 2;
   localparam int AW   = 5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   regfile_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP)) bus ();

   regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: architectural register contents, pending flags, and clear progress
   logic [XLEN-1:0] m_reg  [NREG];
   bit              m_pend [NREG];
   int              m_clr = 0;   // 0: not clearing; otherwise the register the next edge zeroes

   function automatic logic [XLEN-1:0] obs_data(int p);
      return bus.rs_data[p*XLEN +: XLEN];
   endfunction

   function automatic logic obs_busy(int p);
      return bus.rs_busy[p];
   endfunction

   function automatic logic [AW-1:0] port_addr(int p);
      return bus.rs_addr[p*AW +: AW];
   endfunction

   function automatic logic [XLEN-1:0] exp_data(logic [AW-1:0] a);
      if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
      if (m_clr == 0 && bus.rd_wren && bus.rd_addr == a) return bus.rd_data;
`endif
      return m_reg[a];
   endfunction

   function automatic logic exp_busy(logic [AW-1:0] a);
      if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
      if (m_clr == 0 && bus.rd_wren && bus.rd_addr == a) return 1'b0;
`endif
      return m_pend[a];
   endfunction

   task automatic idle_inputs();
      bus.rd_wren  = 1'b0;
      bus.rd_addr  = '0;
      bus.rd_data  = '0;
      bus.iss_en   = 1'b0;
      bus.iss_addr = '0;
      bus.clr_req  = 1'b0;
   endtask

   task automatic set_ports(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      bus.rs_addr = {a1, a0};
   endtask

   // Apply the architectural rules for one clock edge using the inputs currently driven
   task automatic model_edge();
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 1'b0;
         end
         m_clr = 0;
      end else if (m_clr != 0) begin
         m_reg[m_clr]  = '0;
         m_pend[m_clr] = 1'b0;
         m_clr = (m_clr == NREG - 1) ? 0 : m_clr + 1;
      end else begin
         if (bus.rd_wren && bus.rd_addr != 0) begin
            m_reg[bus.rd_addr]  = bus.rd_data;
            m_pend[bus.rd_addr] = 1'b0;
         end
         if (bus.iss_en && bus.iss_addr != 0) m_pend[bus.iss_addr] = 1'b1;
         if (bus.clr_req) m_clr = 1;
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic write_reg(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      idle_inputs();
      bus.rd_wren = 1'b1;
      bus.rd_addr = a;
      bus.rd_data = d;
      step();
      idle_inputs();
   endtask

   task automatic test_reset();
      int addrs [3] = '{0, 5, 31};
      rst = 1'b1;
      idle_inputs();
      set_ports(0, 0);
      step();
      step();
      rst = 1'b0;
      foreach (addrs[k]) begin
         set_ports(AW'(addrs[k]), AW'(addrs[k]));
         #1;
         for (int p = 0; p < NRP; p++) begin
            checks++;
            if (obs_data(p) !== 32'h0) begin
               errors++;
               $display("FAIL reset_data port%0d r%0d got=%h want=0", p, addrs[k], obs_data(p));
            end
            checks++;
            if (obs_busy(p) !== 1'b0) begin
               errors++;
               $display("FAIL reset_busy port%0d r%0d got=%b want=0", p, addrs[k], obs_busy(p));
            end
         end
         checks++;
         if (bus.clr_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_clr_busy got=%b want=0", bus.clr_busy);
         end
      end
   endtask

   task automatic test_write_r0_r7();
      write_reg(0, 32'hDEADBEEF);
      set_ports(0, 0);
      #1;
      checks++;
      if (obs_data(0) !== 32'h0) begin
         errors++;
         $display("FAIL r0_hardwired got=%h want=0", obs_data(0));
      end
      write_reg(7, 32'h12345678);
      set_ports(7, 7);
      #1;
      for (int p = 0; p < NRP; p++) begin
         checks++;
         if (obs_data(p) !== 32'h12345678) begin
            errors++;
            $display("FAIL r7_read port%0d got=%h want=12345678", p, obs_data(p));
         end
      end
   endtask

   task automatic test_pending();
      idle_inputs();
      bus.iss_en   = 1'b1;
      bus.iss_addr = 9;
      step();
      idle_inputs();
      set_ports(9, 9);
      #1;
      for (int p = 0; p < NRP; p++) begin
         checks++;
         if (obs_busy(p) !== 1'b1) begin
            errors++;
            $display("FAIL issue_busy port%0d got=%b want=1", p, obs_busy(p));
         end
      end
      write_reg(9, 32'hA5A5A5A5);
      #1;
      checks++;
      if (obs_busy(0) !== 1'b0 || obs_data(0) !== 32'hA5A5A5A5) begin
         errors++;
         $display("FAIL wb_retire got busy=%b data=%h want busy=0 data=a5a5a5a5", obs_busy(0), obs_data(0));
      end
      bus.rd_wren  = 1'b1;
      bus.rd_addr  = 9;
      bus.rd_data  = 32'h5A5A5A5A;
      bus.iss_en   = 1'b1;
      bus.iss_addr = 9;
      step();
      idle_inputs();
      #1;
      for (int p = 0; p < NRP; p++) begin
         checks++;
         if (obs_busy(p) !== 1'b1 || obs_data(p) !== 32'h5A5A5A5A) begin
            errors++;
            $display("FAIL iss_wb_same port%0d got busy=%b data=%h want busy=1 data=5a5a5a5a", p, obs_busy(p), obs_data(p));
         end
      end
   endtask

   task automatic test_bypass();
      logic [XLEN-1:0] want;
      idle_inputs();
      set_ports(3, 3);
      bus.rd_wren  = 1'b1;
      bus.rd_addr  = 3;
      bus.rd_data  = 32'hCAFEF00D;
      bus.iss_en   = 1'b1;
      bus.iss_addr = 3;
      #1;
`ifdef REGFILE_BYPASS_EN
      want = 32'hCAFEF00D;
`else
      want = 32'h0;
`endif
      for (int p = 0; p < NRP; p++) begin
         checks++;
         if (obs_data(p) !== want || obs_busy(p) !== 1'b0) begin
            errors++;
            $display("FAIL bypass_same_cycle port%0d got data=%h busy=%b want data=%h busy=0", p, obs_data(p), obs_busy(p), want);
         end
      end
      step();
      idle_inputs();
      #1;
      for (int p = 0; p < NRP; p++) begin
         checks++;
         if (obs_data(p) !== 32'hCAFEF00D || obs_busy(p) !== 1'b1) begin
            errors++;
            $display("FAIL bypass_next_cycle port%0d got data=%h busy=%b want data=cafef00d busy=1", p, obs_data(p), obs_busy(p));
         end
      end
   endtask

   task automatic drive_random();
      logic [AW-1:0] a0, a1;
      bus.rd_wren  = ($urandom_range(0, 1) == 1);
      bus.rd_addr  = AW'($urandom_range(0, NREG - 1));
      bus.rd_data  = $urandom;
      bus.iss_en   = ($urandom_range(0, 2) == 0);
      bus.iss_addr = AW'($urandom_range(0, NREG - 1));
      a0 = ($urandom_range(0, 2) == 0) ? bus.rd_addr : AW'($urandom_range(0, NREG - 1));
      a1 = ($urandom_range(0, 3) == 0) ? a0 : AW'($urandom_range(0, NREG - 1));
      set_ports(a0, a1);
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         drive_random();
         bus.clr_req = 1'b0;
         #1;
         for (int p = 0; p < NRP; p++) begin
            checks++;
            if (obs_data(p) !== exp_data(port_addr(p)) || obs_busy(p) !== exp_busy(port_addr(p))) begin
               errors++;
               $display("FAIL random cyc%0d port%0d r%0d got data=%h busy=%b want data=%h busy=%b", n, p, port_addr(p), obs_data(p), obs_busy(p), exp_data(port_addr(p)), exp_busy(port_addr(p)));
            end
         end
         step();
      end
      idle_inputs();
   endtask

   task automatic test_clear();
      int n = 0;
      for (int r = 1; r < NREG; r++) write_reg(AW'(r), $urandom | 32'h1);
      for (int r = 2; r < NREG; r += 7) begin
         bus.iss_en   = 1'b1;
         bus.iss_addr = AW'(r);
         step();
      end
      idle_inputs();
      bus.clr_req = 1'b1;
      step();
      idle_inputs();
      while (bus.clr_busy === 1'b1 && n < 100) begin
         drive_random();
         bus.clr_req = ($urandom_range(0, 3) == 0);
         #1;
         for (int p = 0; p < NRP; p++) begin
            checks++;
            if (obs_data(p) !== exp_data(port_addr(p)) || obs_busy(p) !== exp_busy(port_addr(p))) begin
               errors++;
               $display("FAIL clear_read cyc%0d port%0d r%0d got data=%h busy=%b want data=%h busy=%b", n, p, port_addr(p), obs_data(p), obs_busy(p), exp_data(port_addr(p)), exp_busy(port_addr(p)));
            end
         end
         step();
         n++;
      end
      idle_inputs();
      checks++;
      if (n != NREG - 1) begin
         errors++;
         $display("FAIL clear_duration got=%0d cycles want=%0d", n, NREG - 1);
      end
      for (int a = 0; a < NREG; a++) begin
         set_ports(AW'(a), AW'(a));
         #1;
         checks++;
         if (obs_data(0) !== 32'h0 || obs_busy(1) !== 1'b0) begin
            errors++;
            $display("FAIL after_clear r%0d got data=%h busy=%b want data=0 busy=0", a, obs_data(0), obs_busy(1));
         end
      end
   endtask

   task automatic test_reset_mid_clear();
      for (int r = 4; r < 30; r += 3) write_reg(AW'(r), 32'h100 + r);
      bus.iss_en   = 1'b1;
      bus.iss_addr = 20;
      step();
      idle_inputs();
      bus.clr_req = 1'b1;
      step();
      idle_inputs();
      for (int k = 0; k < 10; k++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      checks++;
      if (bus.clr_busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_clear clr_busy got=%b want=0", bus.clr_busy);
      end
      for (int a = 0; a < NREG; a++) begin
         set_ports(AW'(a), AW'(a));
         #1;
         checks++;
         if (obs_data(1) !== 32'h0 || obs_busy(0) !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_clear r%0d got data=%h busy=%b want data=0 busy=0", a, obs_data(1), obs_busy(0));
         end
      end
      write_reg(4, 32'h1);
      set_ports(4, 4);
      #1;
      checks++;
      if (obs_data(0) !== 32'h1 || obs_busy(0) !== 1'b0 || bus.clr_busy !== 1'b0) begin
         errors++;
         $display("FAIL post_rst_write got data=%h busy=%b clr_busy=%b want data=1 busy=0 clr_busy=0", obs_data(0), obs_busy(0), bus.clr_busy);
      end
   endtask

   initial begin
      test_reset();
      test_write_r0_r7();
      test_pending();
      test_bypass();
      test_random();
      test_clear();
      test_reset_mid_clear();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end
endmodule
